// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - 4-bit FSM state codes
//   - opcode and R-type funct field constants
//   - ALU control codes and the aluop encoding between FSM and ALU decoder
//   - ctrl_t bundle of per-state Moore outputs, plus a decode helper
// ---------------------------------------------------------------------------
package mips_pkg;

    // FSM state codes (12-15 unused, recovered to FETCH)
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEXEC = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    // Opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    // R-type funct, instr[5:0]
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU control codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // aluop: FSM request to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // Raw per-state controls before pcen is formed and reset masking applied
    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

    // Moore output table; unlisted fields and unused codes are all zero
    function automatic ctrl_t decode_state(input logic [3:0] s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alusrcb = 2'b01;
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
            end
            S_DECODE:   c.alusrcb = 2'b11;
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEMRD:    c.iord = 1'b1;
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_SUB;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            S_ADDIEXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_ADDIWB:   c.regwrite = 1'b1;
            S_JUMP: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control_if
// Bundle between the control unit and the datapath.
//   Datapath -> control : op, funct (from IR), zero (ALU Z flag)
//   Control -> datapath : mux selects, write enables, alucontrol, state
// Modports:
//   master - the control unit
//   slave  - the datapath (or a testbench standing in for it)
// ---------------------------------------------------------------------------
interface mips_multicycle_control_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, state
    );

    modport slave (
        output op, funct, zero,
        input  iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, state
    );
endinterface

// File: rtl/mips_alu_decoder.sv
// ---------------------------------------------------------------------------
// mips_alu_decoder
// Purely combinational: (aluop, funct) -> 3-bit ALU control.
//   aluop_i      [1:0] request from the FSM
//   funct_i      [5:0] R-type function field
//   alucontrol_o [2:0] operation code to the ALU
// Unknown functs and the reserved aluop fall back to ADD.
// ---------------------------------------------------------------------------
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o
);

    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_ADD:  alucontrol_o = ALU_ADD;
            ALUOP_SUB:  alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: alucontrol_o = ALU_ADD;
                    FUNCT_SUB: alucontrol_o = ALU_SUB;
                    FUNCT_AND: alucontrol_o = ALU_AND;
                    FUNCT_OR:  alucontrol_o = ALU_OR;
                    FUNCT_SLT: alucontrol_o = ALU_SLT;
                    default:   alucontrol_o = ALU_ADD;
                endcase
            end
            default:    alucontrol_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control
// Moore FSM sequencing multicycle MIPS instructions (lw, sw, R-type, beq,
// addi, j; optionally bne) and driving every datapath select/enable.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; returns to FETCH from any state
//   bus    mips_multicycle_control_if.master (op/funct/zero in,
//          controls, alucontrol and debug state out)
// Outputs are decoded from the state register; pcen also looks at zero.
// While reset is high all outputs show FETCH values except that memwrite,
// irwrite, regwrite and pcen are held at 0. The debug state output always
// shows the state register itself.
// Optional feature: define MIPS_BNE_EN to add bne (op 000101), which reuses
// the BRANCH state with an inverted zero test. Without it, 000101 is illegal.
// ---------------------------------------------------------------------------
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
)(
    input  logic                              clk,
    input  logic                              reset,
    mips_multicycle_control_if.master         bus
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [3:0] out_state;
    ctrl_t      ctrl;
    logic       bne_active;
    logic       branch_taken;

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            // op is held stable by the datapath, so it still selects lw/sw here
            S_MEMADR:   state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // ---------------- state register (and bne flag) ----------------
`ifdef MIPS_BNE_EN
    logic bne_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
            bne_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_FETCH)
                bne_q <= 1'b0;
            else if (state_q == S_DECODE)
                bne_q <= (bus.op == OP_BNE);
        end
    end

    assign bne_active = bne_q;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bne_active = 1'b0;
`endif

    // ---------------- Moore output decode ----------------
    // Under reset the decode follows FETCH so selects are already settled
    // for the first fetch; the enables are masked below.
    assign out_state = reset ? S_FETCH : state_q;
    assign ctrl      = decode_state(out_state);

    // bne inverts the sense of the zero test for the same BRANCH state
    assign branch_taken = ctrl.branch & (bne_active ? ~bus.zero : bus.zero);

    assign bus.iord     = ctrl.iord;
    assign bus.memwrite = ctrl.memwrite & ~reset;
    assign bus.irwrite  = ctrl.irwrite  & ~reset;
    assign bus.regwrite = ctrl.regwrite & ~reset;
    assign bus.regdst   = ctrl.regdst;
    assign bus.memtoreg = ctrl.memtoreg;
    assign bus.alusrca  = ctrl.alusrca;
    assign bus.alusrcb  = ctrl.alusrcb;
    assign bus.pcsrc    = ctrl.pcsrc;
    assign bus.pcen     = (ctrl.pcwrite | branch_taken) & ~reset;
    assign bus.state    = state_q;

    mips_alu_decoder u_alu_dec (
        .aluop_i      (ctrl.aluop),
        .funct_i      (bus.funct),
        .alucontrol_o (bus.alucontrol)
    );

endmodule
